// File: rtl/move_sched_pkg.sv
// Shared definitions for the move scheduler: turn FSM encoding and dir bit positions.
package move_sched_pkg;

    localparam int unsigned DIR_W = 4;
    localparam int unsigned X_EN  = 0;
    localparam int unsigned X_UP  = 1;
    localparam int unsigned Y_EN  = 2;
    localparam int unsigned Y_UP  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_L   = 2'd1,
        PEND_R   = 2'd2,
        WAIT_REL = 2'd3
    } turn_state_t;

endpackage

// File: rtl/step_tick_gen.sv
// Movement-rate divider: counts 0..CLK_DIV-1 and flags the last count; hold freezes it.
module step_tick_gen #(
    parameter int unsigned CLK_DIV = 25000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic hold,
    output logic tick
);

    localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          tick_q;

    always_comb begin
        count_nxt = (count == LAST) ? '0 : count + CW'(1);
    end

    // tick_q mirrors (count == LAST) so the strobe comes straight from a flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else if (!hold) begin
            count  <= count_nxt;
            tick_q <= (count_nxt == LAST);
        end
    end

    assign tick = tick_q & ~hold;

endmodule

// File: rtl/move_scheduler.sv
// Grid mover: steps x/y at a divided rate and issues one turn pulse per button press.
// Optional MOVE_SCHED_PAUSE_EN adds a pause input that freezes stepping.
module move_scheduler
    import move_sched_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25000000,
    parameter int unsigned COLS    = 16,
    parameter int unsigned ROWS    = 12,
    parameter int unsigned XW      = 4,
    parameter int unsigned YW      = 4
) (
    input  logic             clk,
    input  logic             rstn,
`ifdef MOVE_SCHED_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic [DIR_W-1:0] dir,
    output logic             turn_left,
    output logic             turn_right,
    output logic             step,
    output logic [XW-1:0]    x_pos,
    output logic [YW-1:0]    y_pos
);

    logic hold;
`ifdef MOVE_SCHED_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    step_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .hold (hold),
        .tick (step)
    );

    logic [1:0]  l_sync;
    logic [1:0]  r_sync;
    logic        l_d;
    logic        r_d;
    logic        rise_l;
    logic        rise_r;
    turn_state_t state;
    turn_state_t state_nxt;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    // Two-flop synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            l_sync <= '0;
            r_sync <= '0;
            l_d    <= 1'b0;
            r_d    <= 1'b0;
        end else begin
            l_sync <= {l_sync[0], btn_left};
            r_sync <= {r_sync[0], btn_right};
            l_d    <= l_sync[1];
            r_d    <= r_sync[1];
        end
    end

    assign rise_l = l_sync[1] & ~l_d;
    assign rise_r = r_sync[1] & ~r_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        turn_left  = 1'b0;
        turn_right = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise_l && rise_r) begin
                    state_nxt = WAIT_REL;
                end else if (rise_l) begin
                    state_nxt = PEND_L;
                end else if (rise_r) begin
                    state_nxt = PEND_R;
                end
            end
            PEND_L: begin
                if (step) begin
                    turn_left = 1'b1;
                    state_nxt = WAIT_REL;
                end
            end
            PEND_R: begin
                if (step) begin
                    turn_right = 1'b1;
                    state_nxt  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!l_sync[1] && !r_sync[1]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wrapping neighbour positions; dir sampled in the step cycle, before any turn lands
    always_comb begin
        x_nxt = x_pos;
        y_nxt = y_pos;
        if (dir[X_EN]) begin
            if (dir[X_UP]) begin
                x_nxt = (x_pos == XW'(COLS - 1)) ? '0 : x_pos + XW'(1);
            end else begin
                x_nxt = (x_pos == '0) ? XW'(COLS - 1) : x_pos - XW'(1);
            end
        end
        if (dir[Y_EN]) begin
            if (dir[Y_UP]) begin
                y_nxt = (y_pos == YW'(ROWS - 1)) ? '0 : y_pos + YW'(1);
            end else begin
                y_nxt = (y_pos == '0) ? YW'(ROWS - 1) : y_pos - YW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (step) begin
            x_pos <= x_nxt;
            y_pos <= y_nxt;
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed self-checking bench for move_scheduler at CLK_DIV=4, COLS=4, ROWS=3.
module tb_move_scheduler;
    import move_sched_pkg::*;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned COLS    = 4;
    localparam int unsigned ROWS    = 3;
    localparam int unsigned XW      = 2;
    localparam int unsigned YW      = 2;

    logic          clk;
    logic          rstn;
    logic          btn_left;
    logic          btn_right;
    logic [3:0]    dir;
    logic          turn_left;
    logic          turn_right;
    logic          step;
    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
`ifdef MOVE_SCHED_PAUSE_EN
    logic          pause;
`endif

    int passed = 0;
    int total  = 0;
    int nl;
    int nr;
    int bad;
    int first_step;

    move_scheduler #(
        .CLK_DIV (CLK_DIV),
        .COLS    (COLS),
        .ROWS    (ROWS),
        .XW      (XW),
        .YW      (YW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
`ifdef MOVE_SCHED_PAUSE_EN
        .pause      (pause),
`endif
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .dir        (dir),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .step       (step),
        .x_pos      (x_pos),
        .y_pos      (y_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Leaves the bench 1 time unit after a rising edge with rstn just released
    task automatic do_reset();
        rstn = 1'b0;
        cycn(2);
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        dir       = 4'b0011;
`ifdef MOVE_SCHED_PAUSE_EN
        pause     = 1'b0;
`endif
        cycn(2);
        chk("rst_x", 32'(x_pos), 0);
        chk("rst_y", 32'(y_pos), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_tl", 32'(turn_left), 0);
        chk("rst_tr", 32'(turn_right), 0);

        // x counts up with wrap, y held
        rstn = 1'b1;
        cycn(3);
        chk("a_first_step", 32'(step), 1);
        chk("a_x0", 32'(x_pos), 0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("a_step_low", 32'(step), 0);
            chk("a_x", 32'(x_pos), 32'(i % 4));
            chk("a_y", 32'(y_pos), 0);
            cycn(2);
            chk("a_step_low2", 32'(step), 0);
            cyc();
            chk("a_step_hi", 32'(step), 1);
        end

        // x decrements through the wrap
        dir = 4'b0001;
        do_reset();
        cycn(3);
        chk("b_step", 32'(step), 1);
        cyc();
        chk("b_x3", 32'(x_pos), 3);
        cycn(4);
        chk("b_x2", 32'(x_pos), 2);

        // y increments through the wrap at ROWS
        dir = 4'b1100;
        do_reset();
        cycn(4);
        chk("b_y1", 32'(y_pos), 1);
        cycn(4);
        chk("b_y2", 32'(y_pos), 2);
        cycn(4);
        chk("b_y0", 32'(y_pos), 0);
        chk("b_x_hold", 32'(x_pos), 0);

        // held right button yields a single pulse aligned to the next step
        dir = 4'b0000;
        do_reset();
        btn_right = 1'b1;
        nl = 0; nr = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (turn_right) begin
                nr++;
                if (!step) bad++;
                if (i != 2) bad++;
            end
            if (turn_left) nl++;
        end
        chk("c_tr_pulses", 32'(nr), 1);
        chk("c_tr_aligned", 32'(bad), 0);
        chk("c_tl_none", 32'(nl), 0);
        chk("c_pos_hold", 32'({x_pos, y_pos}), 0);
        btn_right = 1'b0;
        cycn(4);
        chk("c_idle", 32'(dut.state), 32'(IDLE));

        // simultaneous press issues nothing, then FSM is usable again
        do_reset();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        nl = 0; nr = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (turn_left) nl++;
            if (turn_right) nr++;
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (turn_left) nl++;
            if (turn_right) nr++;
        end
        chk("d_no_tl", 32'(nl), 0);
        chk("d_no_tr", 32'(nr), 0);
        chk("d_idle", 32'(dut.state), 32'(IDLE));
        btn_left = 1'b1;
        nl = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (turn_left) begin
                nl++;
                if (!step) bad++;
            end
            if (turn_left && turn_right) bad++;
        end
        btn_left = 1'b0;
        chk("d_tl_after", 32'(nl), 1);
        chk("d_tl_aligned", 32'(bad), 0);

        // reset while a left turn is pending drops it
        dir = 4'b0011;
        do_reset();
        cycn(3);
        chk("e_step", 32'(step), 1);
        btn_left = 1'b1;
        cycn(3);
        chk("e_pend", 32'(dut.state), 32'(PEND_L));
        chk("e_x_moved", 32'(x_pos), 1);
        rstn = 1'b0;
        #1;
        chk("e_rst_x", 32'(x_pos), 0);
        chk("e_rst_y", 32'(y_pos), 0);
        chk("e_rst_step", 32'(step), 0);
        chk("e_rst_tl", 32'(turn_left), 0);
        chk("e_rst_tr", 32'(turn_right), 0);
        chk("e_rst_state", 32'(dut.state), 32'(IDLE));
        btn_left = 1'b0;
        cycn(2);
        rstn = 1'b1;
        nl = 0; first_step = -1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (turn_left) nl++;
            if (step && first_step < 0) first_step = i;
        end
        chk("e_no_tl", 32'(nl), 0);
        chk("e_first_step", 32'(first_step), 2);

`ifdef MOVE_SCHED_PAUSE_EN
        // pause freezes the divider mid-count and resumes from the held value
        dir = 4'b0011;
        do_reset();
        cyc();
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (step) bad++;
        end
        chk("p_no_step", 32'(bad), 0);
        chk("p_x_frozen", 32'(x_pos), 0);
        pause = 1'b0;
        cyc();
        chk("p_resume_low", 32'(step), 0);
        cyc();
        chk("p_resume_step", 32'(step), 1);
        cyc();
        chk("p_x1", 32'(x_pos), 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter CLK_DIV, default 25000000, clock cycles per movement step (minimum 2).
REQ-002 Parameter COLS, default 16, grid column count.
REQ-003 Parameter ROWS, default 12, grid row count.
REQ-004 Parameter XW, default 4, x_pos width; SHALL satisfy 2^XW >= COLS.
REQ-005 Parameter YW, default 4, y_pos width; SHALL satisfy 2^YW >= ROWS.
REQ-006 clk  input  1  single system clock, rising-edge.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 btn_left  input  1  raw asynchronous left-turn button, active-high.
REQ-009 btn_right  input  1  raw asynchronous right-turn button, active-high.
REQ-010 dir  input  4  direction code: bit0 x enable, bit1 x up, bit2 y enable, bit3 y up.
REQ-011 turn_left  output  1  one-cycle left-turn pulse to the direction controller.
REQ-012 turn_right  output  1  one-cycle right-turn pulse to the direction controller.
REQ-013 step  output  1  one-cycle movement strobe.
REQ-014 x_pos  output  XW  current column.
REQ-015 y_pos  output  YW  current row.

Function
REQ-016 Two-flop synchronizer on each button; all button logic uses synchronized levels only.
REQ-017 Divider counts 0..CLK_DIV-1, wraps to 0; step high exactly in the cycle the count equals CLK_DIV-1.
REQ-018 Turn FSM states: IDLE, PEND_L, PEND_R, WAIT_REL.
REQ-019 IDLE: rising edge of left only -> PEND_L; right only -> PEND_R; both in same cycle -> WAIT_REL, no turn issued.
REQ-020 PEND_x: on a step cycle, assert turn_x for that single cycle, then -> WAIT_REL; button edges while pending ignored.
REQ-021 WAIT_REL: -> IDLE when both synchronized buttons are low; at most one turn per press and at most one turn per step.
REQ-022 On step: dir[0]=1 moves x (+1 if dir[1]=1, else -1); dir[2]=1 moves y (+1 if dir[3]=1, else -1); disabled axis holds.
REQ-023 Position update at a step uses the dir present in that cycle (pre-turn); a turn issued at a step affects the following step.
REQ-024 Wrap: x increments COLS-1 -> 0, decrements 0 -> COLS-1; y likewise with ROWS.
REQ-025 dir enabling both axes moves both on the same step; dir=0000 holds position.
REQ-026 turn_left and turn_right SHALL never both be high in one cycle.

Reset
REQ-027 rstn low: x_pos=0, y_pos=0, step=0, turn_left=0, turn_right=0, divider=0, synchronizers=0, FSM=IDLE.
REQ-028 Reset mid-operation discards any pending turn; first step after release occurs CLK_DIV cycles after rstn deasserts.

Configuration
REQ-029 Macro MOVE_SCHED_PAUSE_EN defined: extra input port pause (1 bit); while high, divider holds, step=0, positions hold, pending turn held but not issued; FSM edge detection still active.
REQ-030 Macro undefined: no pause port; behaviour identical to pause permanently 0.

Structure
REQ-031 Shared package move_sched_pkg holds FSM state encoding and dir bit-index constants (X_EN=0, X_UP=1, Y_EN=2, Y_UP=3).
REQ-032 Divider is sub-module step_tick_gen (params CLK_DIV; ports clk, rstn, hold, tick).

Verification (CLK_DIV=4, COLS=4, ROWS=3)
REQ-033 Reset release, dir=0011 -> step every 4th cycle; x_pos 0,1,2,3,0; y_pos stays 0.
REQ-034 dir=0001 from reset -> x_pos 0 -> 3 -> 2; dir=1100 -> y_pos 0,1,2,0.
REQ-035 btn_right held 20 cycles -> exactly one turn_right pulse, coincident with next step; none on later steps until release.
REQ-036 btn_left and btn_right rise in same cycle -> no turn pulse; FSM returns IDLE after both released.
REQ-037 Press left then assert rstn low before next step -> no turn_left after reset; all outputs at reset values.
REQ-038 MOVE_SCHED_PAUSE_EN: pause high for 10 cycles mid-count -> no step, positions frozen; divider resumes from held count.
